// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: CPU external memory bus between the core and the bridge
interface mem_io_bridge_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    modport master (output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
    modport slave  (input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: steers CPU byte accesses to RAM or memory-mapped I/O (UART TX FIFO, RX pop, cycle counter, halt)
module mem_io_bridge #(
    parameter int TX_DEPTH   = 4,
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    mem_io_bridge_if.slave        bus,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_full,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_pop,
    output logic                  halt,
    output logic                  halt_done
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic          io, rd_io, wr_io, push, pop, push_ok, full_q, src_io, src_vld;
    logic [2:0]    off;
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   cnt, latch;
    logic [7:0]    io_byte, io_byte_nxt;
    logic          unused_hi;

    assign unused_hi = ^bus.mem_a[31:18];
    assign io        = bus.mem_a[17:16] == 2'b11;
    assign off       = bus.mem_a[2:0];
    assign rd_io     = io && !bus.mem_wr;
    assign wr_io     = io && bus.mem_wr;

    assign ram_en    = !io;
    assign ram_wr    = bus.mem_wr && !io;
    assign ram_a     = bus.mem_a[RAM_ADDR_W-1:0];
    assign ram_wdata = bus.mem_dout;

    assign io_byte_nxt = !rd_io      ? 8'h00 :
                         off == 3'd0 ? (rx_valid ? rx_data : 8'h00) :
                         off == 3'd4 ? cnt[7:0] :
                         off == 3'd5 ? latch[15:8] :
                         off == 3'd6 ? latch[23:16] :
                         off == 3'd7 ? latch[31:24] : 8'h00;
    assign rx_pop = rst_in && rd_io && off == 3'd0 && rx_valid;

    // a pop in the same cycle frees a slot, so a push onto a full FIFO is kept
    assign push      = wr_io && off == 3'd0 && bus.mem_dout != 8'h00;
    assign pop       = tx_valid && !tx_full;
    assign push_ok   = push && (count != CW'(TX_DEPTH) || pop);
    assign count_nxt = count + CW'(push_ok) - CW'(pop);
    assign tx_valid  = count != '0;
    assign tx_data   = fifo[head];

    assign bus.mem_din        = !src_vld ? 8'h00 : src_io ? io_byte : ram_rdata;
    assign bus.io_buffer_full = full_q || (tx_full && tx_valid);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            full_q    <= 1'b0;
            src_io    <= 1'b0;
            src_vld   <= 1'b0;
            cnt       <= '0;
            latch     <= '0;
            io_byte   <= '0;
            halt      <= 1'b0;
            halt_done <= 1'b0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count     <= count_nxt;
            full_q    <= count_nxt >= CW'(TX_DEPTH - 1);
            src_io    <= io;
            src_vld   <= 1'b1;
            cnt       <= cnt + 32'd1;
            io_byte   <= io_byte_nxt;
            if (rd_io && off == 3'd4) latch <= cnt;
            if (wr_io && off == 3'd4) halt <= 1'b1;
            halt_done <= halt && count == '0;
        end
    end

    always_ff @(posedge clk_in)
        if (push_ok) fifo[tail] <= bus.mem_dout;
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU's external memory bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
- Steers each byte access to the 128 KB RAM or to the memory-mapped I/O space, where mem_a[17:16]==2'b11.
- Holds a small UART TX FIFO, an RX pop path, a free-running cycle counter readable at 0x30004, and the program-stop flag.
- Returns read data to the CPU exactly one cycle after the request.

Parameters:
- TX_DEPTH, 4: TX FIFO entries (power of two, >=2).
- RAM_ADDR_W, 17: RAM byte-address width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- mem_a  in  32  CPU address; only [17:0] decoded
- mem_dout  in  8  CPU write data
- mem_wr  in  1  1 = write, 0 = read; an access is issued every cycle
- mem_din  out  8  read data to CPU, valid the cycle after the request
- io_buffer_full  out  1  tells the CPU not to issue an I/O write
- ram_en  out  1  RAM access enable
- ram_wr  out  1  RAM write enable
- ram_a  out  RAM_ADDR_W  RAM address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, 1-cycle latency
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_full  in  1  UART cannot accept; a byte transfers when tx_valid && !tx_full
- rx_data  in  8  UART received byte
- rx_valid  in  1  rx_data holds an unread byte
- rx_pop  out  1  one-cycle pulse consuming rx_data
- halt  out  1  program-stop flag (sticky)
- halt_done  out  1  halt set and TX FIFO empty

Behaviour:
- Clocking and reset:
  - One clock, clk_in. Reset rst_in is asynchronous and active-low.
  - While rst_in=0: FIFO is emptied; counter=0; halt=0; halt_done=0; mem_din=0; tx_valid=0; rx_pop=0; read-source register=RAM.
- Decode:
  - io = (mem_a[17:16]==2'b11). RAM access otherwise.
  - ram_en=!io, ram_wr=mem_wr&&!io, ram_a=mem_a[RAM_ADDR_W-1:0], ram_wdata=mem_dout.
  - These RAM outputs are combinational.
- Read path:
  - A register captures {io, mem_a[2:0]} every cycle.
  - Next cycle, mem_din = ram_rdata if the captured access was RAM, else the registered I/O byte produced below.
- I/O reads (mem_wr=0, io=1):
  - Offset 0 (0x30000):
    - rx_valid=1: I/O byte=rx_data and rx_pop pulses for that cycle.
    - rx_valid=0: I/O byte=0x00 and no pop.
  - Offset 4 (0x30004): snapshot the counter into a 32-bit latch; I/O byte=counter[7:0].
  - Offsets 5, 6, 7: return latch[15:8], [23:16], [31:24]. The latch is updated only by an offset-4 read.
  - Other offsets read 0x00.
- I/O writes (mem_wr=1, io=1):
  - Offset 0, data != 0x00: push into the TX FIFO.
  - Offset 0, data == 0x00: ignored (no push).
  - Offset 4, any data: set halt=1. halt is cleared only by reset.
  - Other offsets ignored.
  - A push while the FIFO is full is dropped; the CPU must honour io_buffer_full.
- TX FIFO:
  - Circular, head/tail pointers of log2(TX_DEPTH) bits wrapping modulo TX_DEPTH, plus a count register.
  - tx_valid = (count!=0); tx_data = head entry; pop when tx_valid && !tx_full.
  - Push and pop in the same cycle: count unchanged, both pointers advance. On a full FIFO this is legal and not dropped, because the pop frees space.
- io_buffer_full:
  - Registered: 1 when next count >= TX_DEPTH-1, which gives one cycle of margin for a write already issued.
  - Also forced 1 when tx_full=1 and count!=0.
- Cycle counter:
  - 32-bit, +1 every cycle after reset deasserts; wraps 0xFFFFFFFF -> 0.
  - When an offset-4 read coincides with an increment, the latch takes the pre-increment value.
- halt_done = halt && count==0, registered.

Test Plan:
- Reset mid-operation: fill the FIFO with 3 bytes, pull rst_in low asynchronously (between clock edges) -> tx_valid=0, halt=0, counter=0 immediately, with no clock edge required.
- RAM: write 0x5A to 0x00100, then read 0x00100 -> ram_wr pulses once; mem_din=0x5A exactly one cycle after the read request.
- UART TX: tx_full=1, write 0x41, 0x42, 0x43 to 0x30000 -> io_buffer_full=1 after the 3rd push (TX_DEPTH=4). Release tx_full -> tx_data sequence 0x41, 0x42, 0x43. A write of 0x00 produces no push.
- FIFO full with simultaneous push and pop: count stays 4, no byte is lost, order is preserved across pointer wrap.
- Counter: preload via 0xFFFFFFFE cycles (or force) and read 0x30004..0x30007 -> bytes are consistent with the snapshot value; counter wraps to 0.
- RX and halt: rx_valid=1 with rx_data=0x31, read 0x30000 -> mem_din=0x31 next cycle, rx_pop a single-cycle pulse. Then write 0x30004 with 2 bytes queued -> halt=1 at once; halt_done=1 only after both bytes drain.
